// File: rtl/hs_arb_pkg.sv
// Shared types and default bus widths for the hiscore work-RAM arbiter.
package hs_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VB = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/hs_ram_arbiter_if.sv
// Bundle of hiscore, CPU, video/pause and RAM-port signals around the arbiter.
interface hs_ram_arbiter_if
  import hs_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          vblank;
  logic          user_pause;
  logic          hs_access;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in;
  logic          hs_write;
  logic          hs_grant;
  logic [DW-1:0] hs_data_out;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_we;
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          cpu_pause;

  modport slave (
    input  vblank, user_pause, hs_access, hs_address, hs_data_in, hs_write,
           cpu_addr, cpu_dout, cpu_we, ram_dout,
    output hs_grant, hs_data_out, ram_addr, ram_din, ram_we, cpu_pause
  );

  modport master (
    output vblank, user_pause, hs_access, hs_address, hs_data_in, hs_write,
           cpu_addr, cpu_dout, cpu_we, ram_dout,
    input  hs_grant, hs_data_out, ram_addr, ram_din, ram_we, cpu_pause
  );

endinterface

// File: rtl/hs_ram_arbiter.sv
// Hands the core work-RAM port to the hiscore engine during vblank, with the
// CPU paused for a settle period first and kept paused for one release clock.
//   state      | meaning
//   ST_IDLE    | CPU owns RAM, no request
//   ST_WAIT_VB | request seen, waiting for vertical blank
//   ST_SETTLE  | CPU held, counting down before grant
//   ST_GRANT   | hiscore engine owns RAM
//   ST_RELEASE | one clock back on CPU mux, CPU still held
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int SETTLE = 4,
  parameter int CNTW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  hs_ram_arbiter_if.slave   bus
);

  arb_state_t    r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_hold, w_hold_nxt;
  logic [DW-1:0] r_data_out;

  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din;
  logic          w_ram_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_grant    <= 1'b0;
      r_hold     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_hold  <= w_hold_nxt;
      if (r_grant) r_data_out <= bus.ram_dout;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (bus.hs_access) w_state_nxt = ST_WAIT_VB;
      end
      ST_WAIT_VB: begin
        if (!bus.hs_access) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.vblank) begin
          w_state_nxt = ST_SETTLE;
          w_hold_nxt  = 1'b1;
          w_cnt_nxt   = CNTW'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        // A request withdrawn before expiry still goes through RELEASE.
        if (!bus.hs_access) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bus.hs_access) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = 1'b0;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 1'b0;
        w_hold_nxt  = 1'b0;
      end
    endcase
  end

  // A paused CPU may still present a stale write strobe; block it while held.
  always_comb begin
    if (r_grant) begin
      w_ram_addr = bus.hs_address;
      w_ram_din  = bus.hs_data_in;
      w_ram_we   = bus.hs_write;
    end else begin
      w_ram_addr = bus.cpu_addr;
      w_ram_din  = bus.cpu_dout;
      w_ram_we   = bus.cpu_we & ~r_hold;
    end
  end

  assign bus.ram_addr    = w_ram_addr;
  assign bus.ram_din     = w_ram_din;
  assign bus.ram_we      = w_ram_we;
  assign bus.hs_grant    = r_grant;
  assign bus.hs_data_out = r_data_out;
  assign bus.cpu_pause   = r_hold | bus.user_pause;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench: driver predicts each cycle's outputs from a timestamp-style
// model and queues them; a negedge monitor pops and compares.
module tb_hs_ram_arbiter;

  localparam int SETTLE_C = 4;

  typedef struct packed {
    logic        grant;
    logic        pause;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic [7:0]  dout;
  } exp_t;

  logic clk;
  logic reset;

  hs_ram_arbiter_if #(.AW(16), .DW(8)) bus ();

  hs_ram_arbiter #(.AW(16), .DW(8), .SETTLE(SETTLE_C), .CNTW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  // stimulus values applied on the next tick
  logic        s_reset, s_vb, s_up, s_acc, s_hwr, s_cwe;
  logic [15:0] s_haddr, s_caddr;
  logic [7:0]  s_hdin, s_cdout;

  // reference model: request waiting, CPU held, grant, release pending
  logic       m_wait, m_hold, m_grant, m_rel, m_started;
  int         m_held;
  logic [7:0] m_dout, m_rd;
  logic [7:0] m_mem [0:65535];
  exp_t       e_cur;

  exp_t sb[$];
  int   n_pass, n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic apply();
    reset          = s_reset;
    bus.vblank     = s_vb;
    bus.user_pause = s_up;
    bus.hs_access  = s_acc;
    bus.hs_address = s_haddr;
    bus.hs_data_in = s_hdin;
    bus.hs_write   = s_hwr;
    bus.cpu_addr   = s_caddr;
    bus.cpu_dout   = s_cdout;
    bus.cpu_we     = s_cwe;
  endtask

  // Advance the model over one clock edge using the inputs held during the
  // cycle that is ending.
  task automatic model_edge();
    logic [7:0] rd_new;
    rd_new = m_rd;
    if (m_started) begin
      rd_new = m_mem[e_cur.addr];
      if (e_cur.we) m_mem[e_cur.addr] = e_cur.din;
    end
    if (reset) begin
      m_wait = 0; m_hold = 0; m_grant = 0; m_rel = 0; m_held = 0; m_dout = 8'h00;
    end else begin
      if (m_grant) m_dout = m_rd;
      if (m_rel) begin
        m_rel = 0; m_hold = 0;
      end else if (m_hold) begin
        if (!bus.hs_access) begin
          m_grant = 0; m_rel = 1;
        end else if (!m_grant) begin
          m_held++;
          if (m_held == SETTLE_C) m_grant = 1;
        end
      end else if (m_wait) begin
        if (!bus.hs_access) m_wait = 0;
        else if (bus.vblank) begin
          m_wait = 0; m_hold = 1; m_held = 0;
        end
      end else if (bus.hs_access) begin
        m_wait = 1;
      end
    end
    m_rd = rd_new;
    m_started = 1;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.grant = m_grant;
    e.pause = m_hold | s_up;
    e.dout  = m_dout;
    if (m_grant) begin
      e.addr = s_haddr; e.din = s_hdin; e.we = s_hwr;
    end else begin
      e.addr = s_caddr; e.din = s_cdout; e.we = s_cwe & ~m_hold;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    apply();
    e_cur = predict();
    sb.push_back(e_cur);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hs_grant",    32'(bus.hs_grant),    32'(e.grant));
        chk("cpu_pause",   32'(bus.cpu_pause),   32'(e.pause));
        chk("ram_addr",    32'(bus.ram_addr),    32'(e.addr));
        chk("ram_din",     32'(bus.ram_din),     32'(e.din));
        chk("ram_we",      32'(bus.ram_we),      32'(e.we));
        chk("hs_data_out", 32'(bus.hs_data_out), 32'(e.dout));
      end
    end
  end

  task automatic grant_cycle(input int hold_cycles);
    s_acc = 1; s_vb = 0;
    repeat (3) tick();
    s_vb = 1; tick();
    s_vb = 0;
    repeat (hold_cycles) tick();
  endtask

  initial begin : driver
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'h00;
      m_mem[i]   = 8'h00;
    end
    m_wait = 0; m_hold = 0; m_grant = 0; m_rel = 0; m_started = 0;
    m_held = 0; m_dout = 8'h00; m_rd = 8'h00; e_cur = '0;

    s_reset = 1; s_vb = 0; s_up = 0; s_acc = 0; s_hwr = 0; s_cwe = 0;
    s_haddr = 16'h0000; s_caddr = 16'h8123; s_hdin = 8'h00; s_cdout = 8'h3C;
    apply();

    // reset with CPU writing
    s_cwe = 1;
    repeat (3) tick();

    // long wait for vblank, then settle and grant with CPU strobe active
    s_reset = 0; s_acc = 1;
    repeat (100) tick();
    s_vb = 1; tick();
    s_vb = 0;
    repeat (6) tick();

    // hiscore write then read-back
    s_haddr = 16'h8040; s_hdin = 8'hA5; s_hwr = 1; tick();
    s_hwr = 0; s_hdin = 8'h00;
    repeat (4) tick();

    // release
    s_acc = 0;
    repeat (4) tick();

    // request withdrawn during settle
    s_acc = 1; repeat (2) tick();
    s_vb = 1; tick();
    s_vb = 0; repeat (2) tick();
    s_acc = 0; repeat (5) tick();

    // user pause across a full grant/release, then reset mid-grant
    s_up = 1;
    grant_cycle(8);
    s_acc = 0; repeat (4) tick();
    grant_cycle(7);
    s_reset = 1; tick();
    s_reset = 0; s_acc = 0; s_up = 0;
    repeat (4) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) s_acc = ~s_acc;
      if ($urandom_range(0, 63) == 0) s_up = ~s_up;
      s_vb    = ($urandom_range(0, 31) < 4);
      s_reset = ($urandom_range(0, 299) == 0);
      s_haddr = 16'h8040 + 16'($urandom_range(0, 7));
      s_caddr = 16'h8040 + 16'($urandom_range(0, 7));
      s_hdin  = 8'($urandom);
      s_cdout = 8'($urandom);
      s_hwr   = ($urandom_range(0, 2) == 0);
      s_cwe   = ($urandom_range(0, 2) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game core's work-RAM port between the Z80 CPU and the hiscore save/restore engine.
- On a hiscore access request it waits for vertical blank, then pauses the CPU. After a settle period it grants the RAM port to the hiscore engine. It returns the port to the CPU once the request drops.
- It sits between the hiscore module, the pause system and the core RAM, and replaces direct hs_pause wiring.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- SETTLE, 4, number of clocks the CPU is held paused before grant (≥1).
- CNTW, 3, settle counter width; must satisfy 2^CNTW ≥ SETTLE.

Ports:
- clk  in  1  system clock (clk_sys, 24 MHz).
- reset  in  1  synchronous, active-high reset.
- vblank  in  1  vertical blank from video timing.
- user_pause  in  1  pause request from the OSD/user pause logic.
- hs_access  in  1  hiscore engine requests the RAM port.
- hs_address  in  AW  hiscore RAM address.
- hs_data_in  in  DW  hiscore write data.
- hs_write  in  1  hiscore write strobe.
- hs_grant  out  1  RAM port currently owned by the hiscore engine.
- hs_data_out  out  DW  registered RAM read data for the hiscore engine.
- cpu_addr  in  AW  CPU RAM address.
- cpu_dout  in  DW  CPU write data.
- cpu_we  in  1  CPU write enable.
- ram_dout  in  DW  RAM read data (synchronous RAM, 1-clock read latency).
- ram_addr  out  AW  muxed RAM address.
- ram_din  out  DW  muxed RAM write data.
- ram_we  out  1  muxed RAM write enable.
- cpu_pause  out  1  CPU clock-enable hold (hiscore hold OR user_pause).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE, counter=0.
  - hs_grant=0, hs_data_out=0, internal hs_hold=0.
  - cpu_pause follows user_pause only.
- States: IDLE, WAIT_VB, SETTLE, GRANT, RELEASE.
- IDLE: hs_access=1 → WAIT_VB.
- WAIT_VB:
  - hs_access=0 → IDLE.
  - Else vblank=1 → SETTLE; hs_hold←1 and counter←SETTLE-1.
- SETTLE:
  - Counter decrements each clock; when counter=0 → GRANT with hs_grant←1.
  - hs_access dropping here → RELEASE; no grant is issued.
- GRANT:
  - Stays while hs_access=1.
  - hs_access=0 → RELEASE with hs_grant←0.
- RELEASE: one clock with ram_we forced 0 and the mux back on the CPU, hs_hold still 1. Then → IDLE, hs_hold←0.
- Registered flags: hs_grant and hs_hold are registered and change on the edge of the state transition.
- cpu_pause = hs_hold | user_pause, combinational OR of registered hs_hold with the input. Asserted in SETTLE, GRANT and RELEASE.
- RAM mux (combinational, zero latency):
  - hs_grant=1: ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write.
  - Else: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_we & ~hs_hold.
- Paused-CPU writes: CPU writes are suppressed while hs_hold=1 (SETTLE, RELEASE), so a paused CPU's stale strobe cannot write.
- Read path: hs_data_out←ram_dout every clock while hs_grant=1; held otherwise. Read data for an address presented in cycle N is valid on hs_data_out after edge N+2.
- Deliberate hs_write: hs_write while hs_grant=0 is ignored.
- vblank ending: vblank falling during SETTLE/GRANT has no effect; once held, the CPU stays paused until release.
- Back-to-back requests: hs_access re-asserted in RELEASE is not seen until IDLE; a new request waits for the next vblank.
- user_pause: active during a grant keeps cpu_pause=1 after release; arbitration is unaffected.
- Reset mid-grant: the next edge returns to IDLE, hs_grant=0 and the CPU owns RAM.

Decomposition:
- Package hs_arb_pkg: state enum typedef (IDLE, WAIT_VB, SETTLE, GRANT, RELEASE) and default width constants AW/DW.
- No sub-module; the RAM mux is a few assigns inside this block.

Test Plan:
1. Reset held 3 clocks with cpu_addr=16'h8123, cpu_we=1 → hs_grant=0, cpu_pause=0, ram_addr=16'h8123, ram_we=1.
2. hs_access=1 with vblank=0 for 100 clocks, then vblank=1 at clock T → cpu_pause=1 after edge T+1; hs_grant=1 after edge T+1+SETTLE (T+5); cpu_we=1 during this window gives ram_we=0.
3. Granted, hs_address=16'h8040, hs_data_in=8'hA5, hs_write=1 for 1 clock → ram_addr=16'h8040, ram_din=8'hA5, ram_we=1 that cycle; next read of 16'h8040 with RAM model returning 8'hA5 → hs_data_out=8'hA5 two edges later.
4. Granted, hs_access drops at edge E → hs_grant=0 after E; cpu_pause=1 through RELEASE, cpu_pause=0 after E+1; cpu_we=1 at E+1 gives ram_we=0, and cpu_we=1 at E+2 gives ram_we=1.
5. hs_access pulses 2 clocks during SETTLE (drops before counter expiry) → hs_grant never 1, RELEASE then IDLE, cpu_pause=0 afterwards.
6. user_pause=1 throughout a full grant cycle → cpu_pause stays 1 before, during and after; grant and release timing identical to scenario 2/4; reset asserted mid-GRANT → hs_grant=0 and cpu_pause=user_pause on the next edge.
